mem_arbiter: RTL and testbench

Two-port arbiter that shares the single off-chip Data_Memory port (256-bit line, enable/write/ack handshake) between the instruction-cache refill path (requester 1) and the data cache (requester 0). It sits between the caches and Data_Memory at the CPU top level. It grants one requester at a time with round-robin priority and forwards that requester's request to memory. It holds the grant until memory acknowledges and inserts a one-cycle release gap before the next grant. A timeout watchdog flags a hung transaction.

---
 rtl/mem_arbiter.sv | 129 ++++++++++++
 tb/tb_mem_arbiter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single Data_Memory line port between the data cache
// (requester 0) and the instruction-cache refill path (requester 1).
// Round-robin grant, grant held until memory ack, one-cycle release gap,
// and a timeout watchdog that raises a sticky error flag.
module mem_arbiter #(
   parameter int TIMEOUT = 64,
   parameter int CNT_W   = 7
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         m0_enable_i,
   input  logic         m0_write_i,
   input  logic [31:0]  m0_addr_i,
   input  logic [255:0] m0_data_i,
   output logic         m0_ack_o,
   output logic [255:0] m0_data_o,
   input  logic         m1_enable_i,
   input  logic         m1_write_i,
   input  logic [31:0]  m1_addr_i,
   input  logic [255:0] m1_data_i,
   output logic         m1_ack_o,
   output logic [255:0] m1_data_o,
   output logic         mem_enable_o,
   output logic         mem_write_o,
   output logic [31:0]  mem_addr_o,
   output logic [255:0] mem_data_o,
   input  logic         mem_ack_i,
   input  logic [255:0] mem_data_i,
   output logic         err_o
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT0  = 2'd1,
      GRANT1  = 2'd2,
      RELEASE = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic             last_grant_q, last_grant_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             err_q, err_d;

   logic             granted;      // in GRANT0 or GRANT1
   logic             sel;          // 1 when requester 1 owns the port
   logic             sel_enable;   // enable of the current owner
   logic             timeout_hit;  // last permitted grant cycle without ack
   logic             active;       // grant in effect and not being reset

   // Decode the current owner and watchdog condition.
   always_comb begin
      granted     = (state_q == GRANT0) || (state_q == GRANT1);
      sel         = (state_q == GRANT1);
      sel_enable  = sel ? m1_enable_i : m0_enable_i;
      timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));
      active      = granted && !rst_i;
   end

   // State register with synchronous reset; last_grant resets to 1 so that
   // requester 0 wins the first tie.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= IDLE;
         last_grant_q <= 1'b1;
         cnt_q        <= '0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         cnt_q        <= cnt_d;
         err_q        <= err_d;
      end
   end

   // Next-state logic: arbitration in IDLE, completion / early drop / timeout
   // in GRANTx, single-cycle RELEASE gap.
   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      cnt_d        = cnt_q;
      err_d        = err_q;
      case (state_q)
         IDLE: begin
            if (m0_enable_i && (!m1_enable_i || last_grant_q)) begin
               state_d      = GRANT0;
               last_grant_d = 1'b0;
               cnt_d        = '0;
            end else if (m1_enable_i) begin
               state_d      = GRANT1;
               last_grant_d = 1'b1;
               cnt_d        = '0;
            end
         end
         GRANT0, GRANT1: begin
            if (mem_ack_i) begin
               // An ack coincident with an enable drop is a normal completion.
               state_d = RELEASE;
            end else if (!sel_enable || timeout_hit) begin
               // Abandoned or hung transaction: release without an ack.
               state_d = RELEASE;
               err_d   = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         RELEASE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Output steering: owner's request to memory, ack routed back to the owner
   // only; everything forced low while reset is asserted.
   always_comb begin
      mem_enable_o = active && sel_enable;
      mem_write_o  = active && (sel ? m1_write_i : m0_write_i);
      mem_addr_o   = active ? (sel ? m1_addr_i : m0_addr_i) : 32'd0;
      mem_data_o   = active ? (sel ? m1_data_i : m0_data_i) : 256'd0;
      m0_ack_o     = active && !sel && mem_ack_i;
      m1_ack_o     = active && sel && mem_ack_i;
      m0_data_o    = rst_i ? 256'd0 : mem_data_i;
      m1_data_o    = rst_i ? 256'd0 : mem_data_i;
      err_o        = err_q && !rst_i;
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized two-requester traffic against a transaction-level
// reference (round-robin winner choice, ack+2 cycle re-arbitration point,
// shadow line memory), followed by directed timeout, early-drop and
// mid-transaction reset scenarios.
module tb_mem_arbiter;

   localparam int TO = 8;

   logic         clk = 1'b0;
   logic         rst_i;
   logic         m0_enable_i, m0_write_i, m1_enable_i, m1_write_i;
   logic [31:0]  m0_addr_i, m1_addr_i;
   logic [255:0] m0_data_i, m1_data_i;
   logic         m0_ack_o, m1_ack_o;
   logic [255:0] m0_data_o, m1_data_o;
   logic         mem_enable_o, mem_write_o;
   logic [31:0]  mem_addr_o;
   logic [255:0] mem_data_o;
   logic         mem_ack_i;
   logic [255:0] mem_data_i;
   logic         err_o;

   mem_arbiter #(.TIMEOUT(TO), .CNT_W(4)) dut (
      .clk_i(clk), .rst_i(rst_i),
      .m0_enable_i(m0_enable_i), .m0_write_i(m0_write_i), .m0_addr_i(m0_addr_i),
      .m0_data_i(m0_data_i), .m0_ack_o(m0_ack_o), .m0_data_o(m0_data_o),
      .m1_enable_i(m1_enable_i), .m1_write_i(m1_write_i), .m1_addr_i(m1_addr_i),
      .m1_data_i(m1_data_i), .m1_ack_o(m1_ack_o), .m1_data_o(m1_data_o),
      .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o), .mem_addr_o(mem_addr_o),
      .mem_data_o(mem_data_o), .mem_ack_i(mem_ack_i), .mem_data_i(mem_data_i),
      .err_o(err_o)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [255:0] rand256();
      logic [255:0] v;
      for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom;
      return v;
   endfunction

   // Environment Data_Memory and the reference's shadow copy.
   logic [255:0] env_mem [16];
   logic [255:0] ref_mem [16];
   int           mem_wait, mem_lat;
   logic [3:0]   mem_idx;

   // Requester state and arbiter reference.
   bit           pend [2];
   bit           rw   [2];
   logic [31:0]  radr [2];
   logic [255:0] rdat [2];
   int           own, free_at, cyc, txn;
   bit           last;
   bit           issue_en;

   task automatic clear_inputs();
      m0_enable_i = 1'b0; m0_write_i = 1'b0; m0_addr_i = 32'd0; m0_data_i = 256'd0;
      m1_enable_i = 1'b0; m1_write_i = 1'b0; m1_addr_i = 32'd0; m1_data_i = 256'd0;
      mem_ack_i   = 1'b0; mem_data_i = 256'd0;
   endtask

   // One reset cycle with every input trying to provoke an output.
   task automatic do_reset();
      @(negedge clk);
      rst_i = 1'b1;
      m0_enable_i = 1'b1; m1_enable_i = 1'b1; m0_write_i = 1'b1; m1_write_i = 1'b1;
      m0_addr_i = $urandom; m1_addr_i = $urandom;
      m0_data_i = rand256(); m1_data_i = rand256();
      mem_ack_i = 1'b1; mem_data_i = rand256();
      #1;
      check_val("rst_mem_en", mem_enable_o, 0);
      check_val("rst_mem_wr", mem_write_o, 0);
      check_val("rst_mem_addr", mem_addr_o, 0);
      check_val("rst_mem_data", mem_data_o, 0);
      check_val("rst_ack0", m0_ack_o, 0);
      check_val("rst_ack1", m1_ack_o, 0);
      check_val("rst_data0", m0_data_o, 0);
      check_val("rst_err", err_o, 0);
      @(negedge clk);
      rst_i = 1'b0;
      clear_inputs();
   endtask

   task automatic rand_cycle();
      int           idx;
      int           win;
      logic [31:0]  exp_addr;
      logic [255:0] exp_data;
      logic         exp_wr;
      @(negedge clk);
      m0_enable_i = pend[0]; m0_write_i = rw[0]; m0_addr_i = radr[0]; m0_data_i = rdat[0];
      m1_enable_i = pend[1]; m1_write_i = rw[1]; m1_addr_i = radr[1]; m1_data_i = rdat[1];
      mem_ack_i   = (mem_wait >= mem_lat);
      mem_data_i  = mem_ack_i ? env_mem[mem_idx] : rand256();
      #1;
      exp_addr = (own >= 0) ? radr[own] : 32'd0;
      exp_data = (own >= 0) ? rdat[own] : 256'd0;
      exp_wr   = (own >= 0) ? rw[own] : 1'b0;
      check_val("mem_en", mem_enable_o, own >= 0);
      check_val("mem_addr", mem_addr_o, exp_addr);
      check_val("mem_wr", mem_write_o, exp_wr);
      check_val("mem_data", mem_data_o, exp_data);
      check_val("ack0", m0_ack_o, (own == 0) && mem_ack_i);
      check_val("ack1", m1_ack_o, (own == 1) && mem_ack_i);
      check_val("data0", m0_data_o, mem_data_i);
      check_val("data1", m1_data_o, mem_data_i);
      check_val("err", err_o, 0);

      // Environment memory reacts to what the arbiter actually drove.
      if (mem_enable_o && mem_ack_i && mem_write_o) env_mem[mem_addr_o[8:5]] = mem_data_o;
      if (mem_enable_o && !mem_ack_i) begin
         mem_wait++;
         mem_idx = mem_addr_o[8:5];
      end else begin
         mem_wait = 0;
         mem_lat  = $urandom_range(1, 5);
      end

      // Reference: completion, then arbitration when the port is free.
      if (own >= 0 && mem_ack_i) begin
         idx = int'(radr[own][8:5]);
         if (!rw[own]) check_val("rd_line", own == 1 ? m1_data_o : m0_data_o, ref_mem[idx]);
         else ref_mem[idx] = rdat[own];
         $display("txn %0d cyc %0d req%0d %s line %0d", txn, cyc, own, rw[own] ? "write" : "read", idx);
         txn++;
         pend[own] = 1'b0;
         own       = -1;
         free_at   = cyc + 2;
      end else if (own < 0 && cyc >= free_at) begin
         win = -1;
         if (pend[0] && pend[1]) win = last ? 0 : 1;
         else if (pend[0]) win = 0;
         else if (pend[1]) win = 1;
         if (win >= 0) begin
            own  = win;
            last = (win == 1);
         end
      end

      // New requests (never in the cycle right after an ack: cyc+1 == free_at-1).
      for (int r = 0; r < 2; r++) begin
         if (issue_en && !pend[r] && (free_at != cyc + 2 || own >= 0 || !pend[r])
             && $urandom_range(0, 2) == 0) begin
            if (!(free_at == cyc + 2 && own < 0 && r == last)) begin
               pend[r] = 1'b1;
               rw[r]   = $urandom_range(0, 1);
               radr[r] = {23'd0, 4'($urandom_range(0, 15)), 5'd0};
               rdat[r] = rand256();
            end
         end
      end
      cyc++;
   endtask

   initial begin
      logic [255:0] line0;
      logic [15:0]  word;
      bit           drained;
      rst_i = 1'b0;
      clear_inputs();
      for (int k = 0; k < 16; k++) begin
         word = 16'h1111 * 16'(k);
         line0[(15 - k)*16 +: 16] = word;
      end
      env_mem[0] = line0;
      ref_mem[0] = line0;
      for (int k = 1; k < 16; k++) begin
         env_mem[k] = rand256();
         ref_mem[k] = env_mem[k];
      end

      // ---------------- randomized traffic ----------------
      do_reset();
      own = -1; free_at = 0; cyc = 0; txn = 0; last = 1'b1;
      mem_wait = 0; mem_lat = 2; mem_idx = 4'd0; issue_en = 1'b1;
      for (int r = 0; r < 2; r++) begin
         pend[r] = 1'b0; rw[r] = 1'b0; radr[r] = 32'd0; rdat[r] = 256'd0;
      end
      // Tie right after reset, as in the basic scenario: m0 writes 0x20, m1 reads 0x400.
      pend[0] = 1'b1; rw[0] = 1'b1; radr[0] = 32'h20;  rdat[0] = rand256();
      pend[1] = 1'b1; rw[1] = 1'b0; radr[1] = 32'h400; rdat[1] = rand256();
      radr[1][8:5] = 4'd0;
      for (int n = 0; n < 500; n++) rand_cycle();
      issue_en = 1'b0;
      drained  = 1'b0;
      for (int n = 0; n < 100 && !drained; n++) begin
         rand_cycle();
         drained = !pend[0] && !pend[1] && own < 0;
      end
      check_val("drain", drained, 1);
      check_val("txn_count", txn >= 20, 1);

      // ---------------- timeout: memory never acks ----------------
      do_reset();
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         m0_enable_i = (i <= 8); m0_write_i = 1'b1; m0_addr_i = 32'h40; m0_data_i = rand256();
         mem_ack_i = (i == 10); mem_data_i = rand256();
         #1;
         check_val("to_en", mem_enable_o, (i >= 1) && (i <= 8));
         check_val("to_err", err_o, i >= 9);
         check_val("to_ack0", m0_ack_o, 0);
         check_val("to_ack1", m1_ack_o, 0);
      end

      // ---------------- early drop by requester 1 ----------------
      do_reset();
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         m1_enable_i = (i <= 3); m1_write_i = 1'b0; m1_addr_i = 32'h400;
         mem_ack_i = (i >= 5); mem_data_i = rand256();
         #1;
         check_val("ed_en", mem_enable_o, (i >= 1) && (i <= 3));
         check_val("ed_addr", mem_addr_o, ((i >= 1) && (i <= 4)) ? 32'h400 : 32'd0);
         check_val("ed_err", err_o, i >= 5);
         check_val("ed_ack1", m1_ack_o, 0);
         check_val("ed_ack0", m0_ack_o, 0);
      end

      // ---------------- ack coincident with enable drop ----------------
      do_reset();
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         m0_enable_i = (i <= 1); m0_addr_i = 32'h60;
         mem_ack_i = (i == 2); mem_data_i = rand256();
         #1;
         check_val("ad_en", mem_enable_o, i == 1);
         check_val("ad_ack0", m0_ack_o, i == 2);
         check_val("ad_err", err_o, 0);
      end

      // ---------------- reset during GRANT0, then a tie ----------------
      do_reset();
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         rst_i = (i == 2);
         m0_enable_i = (i <= 4); m0_addr_i = 32'h20;
         m1_enable_i = (i >= 3); m1_addr_i = 32'h400;
         mem_ack_i = (i == 2) || (i == 4); mem_data_i = rand256();
         #1;
         check_val("mr_en", mem_enable_o, (i == 1) || (i == 4) || (i == 7));
         check_val("mr_addr", mem_addr_o,
                   (i == 1 || i == 4) ? 32'h20 : (i == 7 ? 32'h400 : 32'd0));
         check_val("mr_ack0", m0_ack_o, i == 4);
         check_val("mr_ack1", m1_ack_o, 0);
         check_val("mr_data0", m0_data_o, (i == 2) ? 256'd0 : mem_data_i);
         check_val("mr_err", err_o, 0);
      end
      rst_i = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
